// File: rtl/seq_builder.sv
// seq_builder: grows an LFSR move pattern per round and collects player presses into a matching entry word
module seq_builder #(
  parameter int          MAX_LEN        = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter bit          FREE_RUN       = 1'b1,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        advance,
  input  logic [3:0]  btn,
  output logic [63:0] pattern,
  output logic [63:0] entry,
  output logic        load,
  output logic [5:0]  round_len,
  output logic        collecting,
  output logic        timed_out,
  output logic        btn_err,
  output logic        won
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GEN, COLLECT, LOAD} state_t;
  state_t state, nxt;
  logic [15:0] lfsr, lfsr_nx;
  logic [3:0] btn_q, rise;
  logic [5:0] count;
  logic [TW-1:0] timer;
  logic [1:0] idx;
  logic multi, done, valid, tmo, at_max;
  assign rise = btn & ~btn_q;
  assign multi = |(rise & (rise - 4'd1));
  assign done = count == round_len;
  assign valid = state == COLLECT && !done && rise != 4'd0 && !multi;
  assign tmo = state == COLLECT && !done && !valid && timer == TW'(TIMEOUT_CYCLES - 1);
  assign idx = rise[3] ? 2'd3 : rise[2] ? 2'd2 : rise[1] ? 2'd1 : 2'd0;
  assign lfsr_nx = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
  assign at_max = round_len == 6'(MAX_LEN);
  assign load = state == LOAD;
  assign collecting = state == COLLECT;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state; start overrides everything and restarts the game
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = advance && !at_max ? GEN : IDLE;
      GEN:     nxt = COLLECT;
      COLLECT: nxt = done || tmo ? LOAD : COLLECT;
      LOAD:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (start) nxt = GEN;
  end
  // datapath: pattern growth, press capture, timeout timer, lfsr
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= '0;
      entry <= '0;
      round_len <= '0;
      count <= '0;
      timer <= '0;
      timed_out <= 1'b0;
      btn_err <= 1'b0;
      won <= 1'b0;
      lfsr <= SEED;
      btn_q <= '0;
    end else begin
      btn_q <= btn;
      btn_err <= !start && state == COLLECT && !done && multi;
      if (FREE_RUN || (state == GEN && !start)) lfsr <= lfsr_nx;
      if (start) begin
        round_len <= 6'd1;
        pattern <= '0;
        won <= 1'b0;
        timed_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (advance && at_max) won <= 1'b1;
            if (advance && !at_max) round_len <= round_len + 6'd1;
          end
          GEN: begin
            pattern <= {pattern[61:0], lfsr[1:0]};
            entry <= '0;
            count <= '0;
            timer <= '0;
          end
          COLLECT: begin
            if (valid) begin
              entry <= {entry[61:0], idx};
              count <= count + 6'd1;
            end
            timer <= valid ? '0 : timer + TW'(1);
            if (tmo) timed_out <= 1'b1;
          end
          LOAD: timed_out <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seq_builder.sv
// tb_seq_builder: directed table, corner sequences and random games against a move-queue reference model
module tb_seq_builder;
  localparam int MAXL = 5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, advance = 1'b0;
  logic [3:0] btn = 4'h0;
  logic [63:0] pattern, entry;
  logic load, collecting, timed_out, btn_err, won;
  logic [5:0] round_len;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] lfsr_m;
  int len_m;
  bit won_m;
  logic [1:0] moves[$];
  logic [1:0] presses[$];
  typedef struct {int st; int adv; int b; int ld; int col; int to; int be; int len; longint pat; longint ent;} vec_t;
  vec_t tbl[16];

  seq_builder #(.MAX_LEN(MAXL), .LFSR_SEED(16'hACE1), .FREE_RUN(1'b0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .advance(advance), .btn(btn),
    .pattern(pattern), .entry(entry), .load(load), .round_len(round_len),
    .collecting(collecting), .timed_out(timed_out), .btn_err(btn_err), .won(won)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  function automatic logic [15:0] step(input logic [15:0] l);
    return l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
  endfunction

  function automatic logic [63:0] pack(input logic [1:0] q[$]);
    logic [63:0] r = 64'h0;
    foreach (q[i]) r = r * 64'd4 + 64'(q[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lfsr_m = 16'hACE1;
    len_m = 0;
    won_m = 1'b0;
    moves.delete();
    presses.delete();
  endtask

  task automatic check_idle_reset();
    check("rst_pattern", pattern, 64'h0);
    check("rst_entry", entry, 64'h0);
    check("rst_len", 64'(round_len), 64'h0);
    check("rst_flags", 64'({load, collecting, timed_out, btn_err, won}), 64'h0);
  endtask

  task automatic begin_round(input bit s);
    if (s) begin
      start = 1'b1;
      moves.delete();
      won_m = 1'b0;
      len_m = 1;
    end else begin
      advance = 1'b1;
      len_m++;
    end
    tick();
    start = 1'b0;
    advance = 1'b0;
    check("gen_load", 64'(load), 64'h0);
    check("gen_len", 64'(round_len), 64'(len_m));
    check("gen_won", 64'(won), 64'(won_m));
    moves.push_back(lfsr_m[1:0]);
    lfsr_m = step(lfsr_m);
    presses.delete();
    tick();
    check("col_pattern", pattern, pack(moves));
    check("col_collecting", 64'(collecting), 64'h1);
    check("col_entry", entry, 64'h0);
  endtask

  task automatic press(input int i);
    btn = 4'b0001 << i;
    tick();
    btn = 4'h0;
    presses.push_back(2'(i));
    tick();
    check("press_entry", entry, pack(presses));
  endtask

  task automatic multi();
    logic [3:0] v;
    v = 4'(($urandom_range(0, 10) % 11));
    v = (v == 4'h0 || $countones(v) < 2) ? 4'b0101 : v;
    btn = v;
    tick();
    check("multi_err", 64'(btn_err), 64'h1);
    check("multi_entry", entry, pack(presses));
    btn = 4'h0;
    tick();
    check("multi_err_clr", 64'(btn_err), 64'h0);
  endtask

  task automatic finish_round(input bit to, output int w);
    w = 0;
    while (!load && w < 40) begin
      tick();
      w++;
    end
    check("load_seen", 64'(load), 64'h1);
    check("load_pattern", pattern, pack(moves));
    check("load_entry", entry, pack(presses));
    check("load_timed_out", 64'(timed_out), 64'(to));
    check("load_len", 64'(round_len), 64'(len_m));
    tick();
    check("load_one_cycle", 64'({load, collecting, timed_out}), 64'h0);
  endtask

  task automatic play_game(input bit allow_to);
    int k, w;
    bit to;
    begin_round(1'b1);
    while (1) begin
      to = allow_to && $urandom_range(0, 4) == 0;
      k = to ? int'($urandom_range(0, len_m - 1)) : len_m;
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 3) == 0) multi();
        repeat ($urandom_range(0, 6)) tick();
        press(int'($urandom_range(0, 3)));
      end
      finish_round(to, w);
      if (to) break;
      if (len_m == MAXL) begin
        advance = 1'b1;
        tick();
        advance = 1'b0;
        won_m = 1'b1;
        check("won_set", 64'(won), 64'h1);
        check("won_len", 64'(round_len), 64'(MAXL));
        check("won_idle", 64'(collecting), 64'h0);
        break;
      end
      begin_round(1'b0);
    end
  endtask

  initial begin
    int w;
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0};
    tbl[1]  = '{0, 0, 0, 0, 1, 0, 0, 1, 64'h1, 64'h0};
    tbl[2]  = '{0, 0, 2, 0, 1, 0, 0, 1, 64'h1, 64'h1};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 1, 64'h1, 64'h1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 64'h1, 64'h1};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 2, 64'h1, 64'h1};
    tbl[6]  = '{0, 0, 0, 0, 1, 0, 0, 2, 64'h4, 64'h0};
    tbl[7]  = '{0, 0, 8, 0, 1, 0, 0, 2, 64'h4, 64'h3};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 2, 64'h4, 64'h3};
    tbl[9]  = '{0, 0, 1, 0, 1, 0, 0, 2, 64'h4, 64'hC};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 2, 64'h4, 64'hC};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 2, 64'h4, 64'hC};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 3, 64'h4, 64'hC};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 0, 3, 64'h10, 64'h0};
    tbl[14] = '{0, 0, 3, 0, 1, 0, 1, 3, 64'h10, 64'h0};
    tbl[15] = '{0, 0, 0, 0, 1, 0, 0, 3, 64'h10, 64'h0};
    repeat (2) tick();
    do_reset();
    check_idle_reset();
    for (int i = 0; i < 16; i++) begin
      start = 1'(tbl[i].st);
      advance = 1'(tbl[i].adv);
      btn = 4'(tbl[i].b);
      tick();
      start = 1'b0;
      advance = 1'b0;
      btn = 4'h0;
      check($sformatf("row%0d_pattern", i), pattern, 64'(tbl[i].pat));
      check($sformatf("row%0d_entry", i), entry, 64'(tbl[i].ent));
      check($sformatf("row%0d_len", i), 64'(round_len), 64'(tbl[i].len));
      check($sformatf("row%0d_flags", i), 64'({load, collecting, timed_out, btn_err}),
            64'(tbl[i].ld * 8 + tbl[i].col * 4 + tbl[i].to * 2 + tbl[i].be));
    end
    do_reset();
    check_idle_reset();
    begin_round(1'b1);
    finish_round(1'b1, w);
    check("timeout_cycles", 64'(w), 64'd16);
    begin_round(1'b1);
    press(2);
    finish_round(1'b0, w);
    begin_round(1'b0);
    press(1);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("adv_ignored_len", 64'(round_len), 64'd2);
    check("adv_ignored_col", 64'(collecting), 64'h1);
    begin_round(1'b1);
    press(3);
    finish_round(1'b0, w);
    begin_round(1'b0);
    press(0);
    do_reset();
    check_idle_reset();
    repeat (20) tick();
    check("no_load_after_rst", 64'({load, collecting}), 64'h0);
    play_game(1'b0);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("won_hold", 64'(won), 64'h1);
    check("won_len_sat", 64'(round_len), 64'(MAXL));
    for (int g = 0; g < 25; g++) play_game(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
